// File: rtl/bus_arbiter.sv
// bus_arbiter: four-master round-robin arbiter with master-side request mux.
// A 2-bit owner register is the only state. The current owner holds the bus
// for as long as it keeps req_ low. When it releases, ownership rotates to the
// next requester in the order owner+1, owner+2, owner+3 (mod 4). With no
// requester the bus parks on the last owner. Grants and the shared-bus mux are
// decoded combinationally from the owner register.
module bus_arbiter #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req_,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_as_,
    input  logic              m0_rw,
    input  logic [DATA_W-1:0] m0_wr_data,
    output logic              m0_grnt_,

    input  logic              m1_req_,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_as_,
    input  logic              m1_rw,
    input  logic [DATA_W-1:0] m1_wr_data,
    output logic              m1_grnt_,

    input  logic              m2_req_,
    input  logic [ADDR_W-1:0] m2_addr,
    input  logic              m2_as_,
    input  logic              m2_rw,
    input  logic [DATA_W-1:0] m2_wr_data,
    output logic              m2_grnt_,

    input  logic              m3_req_,
    input  logic [ADDR_W-1:0] m3_addr,
    input  logic              m3_as_,
    input  logic              m3_rw,
    input  logic [DATA_W-1:0] m3_wr_data,
    output logic              m3_grnt_,

    output logic [ADDR_W-1:0] s_addr,
    output logic              s_as_,
    output logic              s_rw,
    output logic [DATA_W-1:0] s_wr_data
);

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    logic [1:0]        r_owner;
    logic [1:0]        w_next_owner;
    logic [1:0]        w_cand1;
    logic [1:0]        w_cand2;
    logic [1:0]        w_cand3;

    logic [3:0]        w_req_;
    logic [3:0]        w_as_;
    logic [3:0]        w_rw;
    logic [ADDR_W-1:0] w_addr    [4];
    logic [DATA_W-1:0] w_wr_data [4];

    // Gather per-master inputs into indexable vectors
    assign w_req_       = {m3_req_, m2_req_, m1_req_, m0_req_};
    assign w_as_        = {m3_as_,  m2_as_,  m1_as_,  m0_as_};
    assign w_rw         = {m3_rw,   m2_rw,   m1_rw,   m0_rw};
    assign w_addr[0]    = m0_addr;
    assign w_addr[1]    = m1_addr;
    assign w_addr[2]    = m2_addr;
    assign w_addr[3]    = m3_addr;
    assign w_wr_data[0] = m0_wr_data;
    assign w_wr_data[1] = m1_wr_data;
    assign w_wr_data[2] = m2_wr_data;
    assign w_wr_data[3] = m3_wr_data;

    // Rotation candidates; the 2-bit sums wrap 3 -> 0 on their own
    assign w_cand1 = r_owner + 2'd1;
    assign w_cand2 = r_owner + 2'd2;
    assign w_cand3 = r_owner + 2'd3;

    // Next owner: hold while the owner requests, else nearest requester, else park
    always_comb begin
        w_next_owner = r_owner;
        if (w_req_[r_owner] != ENABLE_) begin
            if (w_req_[w_cand1] == ENABLE_) begin
                w_next_owner = w_cand1;
            end else if (w_req_[w_cand2] == ENABLE_) begin
                w_next_owner = w_cand2;
            end else if (w_req_[w_cand3] == ENABLE_) begin
                w_next_owner = w_cand3;
            end
        end
    end

    // Owner register; reset parks the bus on master 0 immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner <= 2'd0;
        end else begin
            r_owner <= w_next_owner;
        end
    end

    // Grant decode: exactly one grant low at all times
    always_comb begin
        m0_grnt_ = DISABLE_;
        m1_grnt_ = DISABLE_;
        m2_grnt_ = DISABLE_;
        m3_grnt_ = DISABLE_;
        case (r_owner)
            2'd0:    m0_grnt_ = ENABLE_;
            2'd1:    m1_grnt_ = ENABLE_;
            2'd2:    m2_grnt_ = ENABLE_;
            default: m3_grnt_ = ENABLE_;
        endcase
    end

    // Shared-bus mux; the strobe is masked once the owner drops its request,
    // which also gives the dead cycle during a handover
    always_comb begin
        s_addr    = w_addr[r_owner];
        s_rw      = w_rw[r_owner];
        s_wr_data = w_wr_data[r_owner];
        s_as_     = w_as_[r_owner] | w_req_[r_owner];
    end

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;
    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;
    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    logic clk = 1'b0;
    logic reset;
    logic m0_req_, m1_req_, m2_req_, m3_req_;
    logic m0_as_, m1_as_, m2_as_, m3_as_;
    logic m0_rw, m1_rw, m2_rw, m3_rw;
    logic [ADDR_W-1:0] m0_addr, m1_addr, m2_addr, m3_addr;
    logic [DATA_W-1:0] m0_wr_data, m1_wr_data, m2_wr_data, m3_wr_data;
    logic m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
    logic [ADDR_W-1:0] s_addr;
    logic s_as_, s_rw;
    logic [DATA_W-1:0] s_wr_data;

    int n_total = 0;
    int n_pass  = 0;

    bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .m0_req_(m0_req_), .m0_addr(m0_addr), .m0_as_(m0_as_), .m0_rw(m0_rw), .m0_wr_data(m0_wr_data), .m0_grnt_(m0_grnt_),
        .m1_req_(m1_req_), .m1_addr(m1_addr), .m1_as_(m1_as_), .m1_rw(m1_rw), .m1_wr_data(m1_wr_data), .m1_grnt_(m1_grnt_),
        .m2_req_(m2_req_), .m2_addr(m2_addr), .m2_as_(m2_as_), .m2_rw(m2_rw), .m2_wr_data(m2_wr_data), .m2_grnt_(m2_grnt_),
        .m3_req_(m3_req_), .m3_addr(m3_addr), .m3_as_(m3_as_), .m3_rw(m3_rw), .m3_wr_data(m3_wr_data), .m3_grnt_(m3_grnt_),
        .s_addr(s_addr), .s_as_(s_as_), .s_rw(s_rw), .s_wr_data(s_wr_data)
    );

    // Rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    wire [3:0] grnt = {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        {m0_req_, m1_req_, m2_req_, m3_req_} = 4'b1111;
        {m0_as_, m1_as_, m2_as_, m3_as_}     = 4'b1111;
        {m0_rw, m1_rw, m2_rw, m3_rw}         = {4{READ}};
        m0_addr = 30'h0000_0A00; m1_addr = 30'h0000_0A11;
        m2_addr = 30'h0000_0A22; m3_addr = 30'h0000_0A33;
        m0_wr_data = 32'h0000_0000; m1_wr_data = 32'h1111_1111;
        m2_wr_data = 32'h2222_2222; m3_wr_data = 32'h3333_3333;

        // Reset: master 0 granted, strobe gated by m0_req_
        #3;
        m0_as_ = 1'b0;
        #1;
        chk("rst_grnt", grnt, 4'b1110);
        chk("rst_s_as_gated", s_as_, 1'b1);
        chk("rst_s_addr_m0", s_addr, 30'h0000_0A00);
        #8 reset = 1'b1;
        m0_as_ = 1'b1;
        tick(); tick();
        chk("post_rst_park", grnt, 4'b1110);

        // Single request from m2: grant after the sampling edge
        m2_req_ = 1'b0;
        #1;
        chk("m2_req_before_edge", grnt, 4'b1110);
        tick();
        chk("m2_granted", grnt, 4'b1011);
        m2_addr = 30'h0000_1234; m2_as_ = 1'b0; m2_rw = WRITE; m2_wr_data = 32'hDEAD_BEEF;
        #1;
        chk("m2_s_addr", s_addr, 30'h0000_1234);
        chk("m2_s_as", s_as_, 1'b0);
        chk("m2_s_rw", s_rw, WRITE);
        chk("m2_s_wr_data", s_wr_data, 32'hDEAD_BEEF);
        m0_addr = 30'h0000_0BBB; m0_as_ = 1'b0;
        #1;
        chk("nonowner_no_effect", s_addr, 30'h0000_1234);
        m0_as_ = 1'b1;

        // Handover m2 -> m1 (scan 3,0,1); dead cycle on s_as_
        m2_req_ = 1'b1; m1_req_ = 1'b0;
        #1;
        chk("h21_dead_cycle", s_as_, 1'b1);
        chk("h21_grnt_still_m2", grnt, 4'b1011);
        tick();
        chk("h21_m1_granted", grnt, 4'b1101);
        m2_as_ = 1'b1;

        // Hold under contention for 10 cycles
        m0_req_ = 1'b0; m3_req_ = 1'b0; m1_as_ = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("hold_m1_c%0d", i), grnt, 4'b1101);
        end
        chk("hold_s_as", s_as_, 1'b0);

        // m1 releases with m0, m3 requesting: m3 wins
        m1_req_ = 1'b1;
        #1;
        chk("h13_dead_cycle", s_as_, 1'b1);
        tick();
        chk("h13_m3_granted", grnt, 4'b0111);
        m1_as_ = 1'b1;
        m3_as_ = 1'b0;
        #1;
        chk("m3_s_addr", s_addr, 30'h0000_0A33);

        // m3 releases, wrap to m0
        m3_req_ = 1'b1;
        #1;
        chk("h30_dead_cycle", s_as_, 1'b1);
        tick();
        chk("h30_m0_granted", grnt, 4'b1110);
        m3_as_ = 1'b1;

        // m0 releases, m3 requests: back to m3 (scan 1,2,3)
        m0_req_ = 1'b1; m3_req_ = 1'b0;
        tick();
        chk("h03_m3_granted", grnt, 4'b0111);

        // Parking on m3 with its strobe still low
        m3_as_ = 1'b0; m3_req_ = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("park_m3_c%0d", i), grnt, 4'b0111);
            chk($sformatf("park_s_as_c%0d", i), s_as_, 1'b1);
        end
        m3_req_ = 1'b0;
        #1;
        chk("rereq_s_as_now", s_as_, 1'b0);
        chk("rereq_grnt_now", grnt, 4'b0111);
        tick();
        chk("rereq_grnt_kept", grnt, 4'b0111);
        m3_as_ = 1'b1;

        // m3 -> m2 (scan 0,1,2), then m2 releases with m0 and m3 requesting: m3
        m3_req_ = 1'b1; m2_req_ = 1'b0;
        tick();
        chk("h32_m2_granted", grnt, 4'b1011);
        m2_req_ = 1'b1; m0_req_ = 1'b0; m3_req_ = 1'b0;
        tick();
        chk("simul_m3_wins", grnt, 4'b0111);

        // m3 -> m2 again, m2 accessing, then async reset mid-cycle
        m0_req_ = 1'b1; m3_req_ = 1'b1; m2_req_ = 1'b0;
        tick();
        chk("h32b_m2_granted", grnt, 4'b1011);
        m2_as_ = 1'b0;
        #1;
        chk("m2_access_s_as", s_as_, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("midrst_grnt", grnt, 4'b1110);
        chk("midrst_s_addr_m0", s_addr, 30'h0000_0BBB);
        chk("midrst_s_as_gated", s_as_, 1'b1);
        tick();
        chk("midrst_held", grnt, 4'b1110);
        reset = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Four-master round-robin bus arbiter and master-side multiplexer for the shared system bus. It sits directly downstream of each master's `bus_if` instance: it receives `bus_req_`, `bus_addr`, `bus_as_`, `bus_rw` and `bus_wr_data`, and returns `grnt_`. It forwards the current owner's request signals to the shared bus that feeds the slave decoders. Read data and `rdy_` do not pass through this block; they return to all masters through the slave multiplexer.

## Interface
- `ADDR_W`, default 30: word address width (`WordAddrBus`).
- `DATA_W`, default 32: data width (`WordDataBus`).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `m0_req_` … `m3_req_`  in  1 each  bus request, active low.
- `m0_addr` … `m3_addr`  in  ADDR_W each  master word address.
- `m0_as_` … `m3_as_`  in  1 each  address strobe, active low.
- `m0_rw` … `m3_rw`  in  1 each  `READ`/`WRITE`.
- `m0_wr_data` … `m3_wr_data`  in  DATA_W each  write data.
- `m0_grnt_` … `m3_grnt_`  out  1 each  bus grant, active low.
- `s_addr`  out  ADDR_W  shared-bus address.
- `s_as_`  out  1  shared-bus address strobe, active low.
- `s_rw`  out  1  shared-bus read/write.
- `s_wr_data`  out  DATA_W  shared-bus write data.

## Operation
- **State.** A single 2-bit `owner` register. There is no other state.
- **Grant decode.** Combinational from `owner`. `mi_grnt_` = `ENABLE_` when `owner == i`; otherwise `DISABLE_`. Exactly one grant is low at all times, including when no master is requesting (the bus parks on the last owner).
- **Arbitration.** Evaluated every rising edge.
  - **Hold:** if the current owner's `req_` == `ENABLE_`, `owner` is unchanged. Ownership is never preempted.
  - **Rotate:** otherwise, scan `owner+1`, `owner+2`, `owner+3` (mod 4) in that order. `owner` takes the first index whose `req_` == `ENABLE_`.
  - **Park:** if no master requests, `owner` is unchanged.
- **Request mux.** Combinational, selected by `owner`.
  - `s_addr`, `s_rw` and `s_wr_data` equal the owner's signals.
  - `s_as_` = owner `as_` OR owner `req_`. A strobe from a parked owner that has dropped `req_` never reaches the slaves.
  - Non-owner inputs have no effect on any output.
- **Wrap-around.** `owner` 3 rotates to 0 in modulo-4 arithmetic. The 2-bit register wraps naturally.
- **Simultaneous events.** If the owner releases in the same cycle that several others request, the lowest rotated distance from `owner` wins. Example: owner 2 releases while 0 and 3 request, so 3 wins.
- **Reset.** Asynchronous assertion, including mid-transaction, forces `owner` = 0 immediately.
  - Resulting outputs: `m0_grnt_` = 0 and `m1..m3_grnt_` = 1.
  - `s_*` mirror master 0, with `s_as_` gated by `m0_req_`.
  - Any in-flight access by another master is abandoned. Masters are reset by the same signal.

## Timing
- **Request to grant.** `req_` sampled low at edge E with the bus free gives `grnt_` low right after E (same-cycle combinational decode of the new `owner`). Latency is one clock from `req_` assertion.
- **Owner re-request.** If the owner is also the parked owner and re-asserts `req_`, its grant is already low. Zero extra latency.
- **Handover.** The owner raises `req_` during cycle N and master j requests in cycle N.
  - At the end of N, `owner` = j.
  - `mj_grnt_` falls at the start of N+1.
  - During cycle N, `s_as_` is high, because the old owner's `req_` is high. This guarantees one dead cycle between owners.
- **Grant stability.** `grnt_` stays constant while the owner holds `req_` low, regardless of `as_` or other requests.
- **Mux timing.** `s_*` change only when `owner` changes or the owner's inputs change. There is no registered delay.
- **Reset values.** `m0_grnt_` = 0, `m1_grnt_`–`m3_grnt_` = 1. `s_*` combinational from master 0 inputs.

## Test plan
- **Reset:** all `req_` = 1 and `reset` pulsed low. `m0_grnt_` = 0 and others = 1 during and after reset. With `m0_as_` = 0 and `m0_req_` = 1, `s_as_` = 1.
- **Single request:** `m2_req_` = 0 from cycle 5. `m2_grnt_` = 0 from cycle 6. Then `m2_addr` = 30'h0000_1234, `m2_as_` = 0, `m2_rw` = `WRITE`, `m2_wr_data` = 32'hDEADBEEF must appear on `s_*` that cycle.
- **Hold under contention:** m1 owns with `req_` held low for 10 cycles while m0 and m3 request. `m1_grnt_` stays 0 for all 10 cycles.
- **Rotation with wrap-around:**
  - m1 releases with m0 and m3 requesting: m3 gets the grant next cycle.
  - m3 then releases: m0 gets the grant.
  - Dead cycle: `s_as_` = 1 in each handover cycle.
- **Parking:** owner m3 drops `req_` and no one requests. `m3_grnt_` stays 0 and `s_as_` = 1. m3 re-requests and keeps the grant with no gap.
- **Reset mid-access:** m2 owns with `s_as_` low and `reset` asserted asynchronously mid-cycle. `m0_grnt_` = 0 and `m2_grnt_` = 1 before the next clock edge.
